// File: rtl/calc_seq_unit_if.sv
// Operand/result handshake bundle for calc_seq_unit.
// master: operand source + result consumer side; slave: the calculator.
interface calc_seq_unit_if #(
    parameter int unsigned WIDTH = 8
);
    localparam int unsigned RES_W = 2 * WIDTH;

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [RES_W-1:0] result;
    logic             err;
    logic             busy;

    modport master (
        output in_valid,
        output op,
        output a,
        output b,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  result,
        input  err,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  op,
        input  a,
        input  b,
        input  out_ready,
        output in_ready,
        output out_valid,
        output result,
        output err,
        output busy
    );
endinterface

// File: rtl/calc_seq_unit.sv
// calc_seq_unit: handshaked sum / product / sum+product / product-over-sum unit.
// ADD, MUL and NET complete at the accept edge; RATIO runs a restoring
// divider producing one quotient bit per cycle, MSB first.
// Build option: define CALC_DIV_EN to build the RATIO divider. Without it,
// op=3 completes immediately with result=0, err=1.
module calc_seq_unit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    calc_seq_unit_if.slave  bus
);
    localparam int unsigned RES_W = 2 * WIDTH;
    localparam int unsigned DVS_W = WIDTH + 1;
    localparam int unsigned TRL_W = WIDTH + 2;
    localparam int unsigned CNT_W = $clog2(RES_W + 1);

    localparam logic [1:0] OP_ADD   = 2'd0;
    localparam logic [1:0] OP_MUL   = 2'd1;
    localparam logic [1:0] OP_NET   = 2'd2;
    localparam logic [1:0] OP_RATIO = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [RES_W-1:0] result_q, result_d;
    logic             err_q, err_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [RES_W-1:0] sum_c;
    logic [RES_W-1:0] prod_c;
    logic [RES_W-1:0] net_c;
    logic             accept_c;

`ifdef CALC_DIV_EN
    // Divider datapath: dq holds the unshifted dividend bits in its upper
    // part and the quotient bits collected so far in its lower part.
    logic [RES_W-1:0] dq_q, dq_d;
    logic [DVS_W-1:0] rem_q, rem_d;
    logic [DVS_W-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TRL_W-1:0] trial_c;
    logic [DVS_W-1:0] diff_c;
    logic             qbit_c;
    logic [RES_W-1:0] dq_next_c;
    logic             div_zero_c;
`endif

    // Operand arithmetic, zero-extended so nothing can truncate.
    always_comb begin
        sum_c    = RES_W'(bus.a) + RES_W'(bus.b);
        prod_c   = RES_W'(bus.a) * RES_W'(bus.b);
        net_c    = prod_c + sum_c;
        accept_c = bus.in_valid && in_ready_q;
    end

`ifdef CALC_DIV_EN
    // One restoring-division step: shift in the next dividend bit, try subtract.
    always_comb begin
        trial_c    = {rem_q, dq_q[RES_W-1]};
        qbit_c     = (trial_c >= TRL_W'(dvs_q));
        diff_c     = DVS_W'(trial_c - TRL_W'(dvs_q));
        dq_next_c  = {dq_q[RES_W-2:0], qbit_c};
        div_zero_c = (bus.a == '0) && (bus.b == '0);
    end
`endif

    // Next-state, datapath and registered-output logic.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        err_d    = err_q;
`ifdef CALC_DIV_EN
        dq_d     = dq_q;
        rem_d    = rem_q;
        dvs_d    = dvs_q;
        cnt_d    = cnt_q;
`endif

        unique case (state_q)
            S_IDLE: begin
                if (accept_c) begin
                    state_d = S_DONE;
                    err_d   = 1'b0;
                    unique case (bus.op)
                        OP_ADD: result_d = sum_c;
                        OP_MUL: result_d = prod_c;
                        OP_NET: result_d = net_c;
                        OP_RATIO: begin
`ifdef CALC_DIV_EN
                            if (div_zero_c) begin
                                result_d = '1;
                                err_d    = 1'b1;
                            end else begin
                                state_d = S_DIV;
                                dq_d    = prod_c;
                                rem_d   = '0;
                                dvs_d   = DVS_W'(bus.a) + DVS_W'(bus.b);
                                cnt_d   = CNT_W'(RES_W);
                            end
`else
                            result_d = '0;
                            err_d    = 1'b1;
`endif
                        end
                        default: result_d = '0;
                    endcase
                end
            end

            S_DIV: begin
`ifdef CALC_DIV_EN
                rem_d = qbit_c ? diff_c : trial_c[DVS_W-1:0];
                dq_d  = dq_next_c;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d  = S_DONE;
                    result_d = dq_next_c;
                    err_d    = 1'b0;
                end
`else
                state_d = S_IDLE;
`endif
            end

            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: state_d = S_IDLE;
        endcase

        in_ready_d  = (state_d == S_IDLE);
        out_valid_d = (state_d == S_DONE);
        busy_d      = (state_d != S_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            result_q    <= '0;
            err_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            result_q    <= result_d;
            err_q       <= err_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

`ifdef CALC_DIV_EN
    // Divider working registers; a reset discards any partial quotient.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dq_q  <= '0;
            rem_q <= '0;
            dvs_q <= '0;
            cnt_q <= '0;
        end else begin
            dq_q  <= dq_d;
            rem_q <= rem_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_calc_seq_unit.sv
// Bench for calc_seq_unit (WIDTH=8): directed vector table, random
// transactions against an arithmetic reference model, backpressure and
// mid-division reset sequences. Expectations follow CALC_DIV_EN.
module tb_calc_seq_unit;
    localparam int unsigned W     = 8;
    localparam int unsigned RW    = 2 * W;
    localparam int          NVEC  = 12;
    localparam int          NRAND = 40;

    logic clk;
    logic rst_n;
    int   n_pass;
    int   n_total;

    calc_seq_unit_if #(.WIDTH(W)) bus ();

    calc_seq_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]    op;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        int            hold;
        logic [RW-1:0] res;
        logic          err;
        int            lat;
    } vec_t;

    vec_t vecs [NVEC];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Reference model straight from the arithmetic definitions.
    function automatic void model(input logic [1:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b, output logic [RW-1:0] res,
                                  output logic err, output int lat);
        int unsigned s;
        int unsigned p;
        s   = int'(a) + int'(b);
        p   = int'(a) * int'(b);
        err = 1'b0;
        lat = 1;
        case (op)
            2'd0: res = RW'(s);
            2'd1: res = RW'(p);
            2'd2: res = RW'(p + s);
            default: begin
`ifdef CALC_DIV_EN
                if (s == 0) begin
                    res = '1;
                    err = 1'b1;
                end else begin
                    res = RW'(p / s);
                    lat = RW + 1;
                end
`else
                res = '0;
                err = 1'b1;
`endif
            end
        endcase
    endfunction

    // One full transaction; called at #1 after a rising edge.
    task automatic run_txn(input string name, input logic [1:0] op, input logic [W-1:0] a,
                           input logic [W-1:0] b, input int hold, input logic [RW-1:0] exp_res,
                           input logic exp_err, input int exp_lat);
        int            lat;
        logic          busy_ok;
        logic          stable_ok;
        logic [RW-1:0] held;
        chk({name, ".in_ready_idle"}, 32'(bus.in_ready), 32'd1);
        bus.op        = op;
        bus.a         = a;
        bus.b         = b;
        bus.in_valid  = 1'b1;
        bus.out_ready = (hold == 0);
        @(posedge clk);
        #1;
        // Scramble inputs after the accept edge; they must not matter.
        bus.in_valid = 1'b0;
        bus.op       = 2'($urandom);
        bus.a        = W'($urandom);
        bus.b        = W'($urandom);
        chk({name, ".busy_after_accept"}, 32'(bus.busy), 32'd1);
        lat     = 1;
        busy_ok = 1'b1;
        while (!bus.out_valid && lat < 100) begin
            if (!bus.busy || bus.in_ready) busy_ok = 1'b0;
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            lat++;
        end
        chk({name, ".busy_while_working"}, 32'(busy_ok), 32'd1);
        chk({name, ".out_valid_seen"}, 32'(bus.out_valid), 32'd1);
        chk({name, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({name, ".result"}, 32'(bus.result), 32'(exp_res));
        chk({name, ".err"}, 32'(bus.err), 32'(exp_err));
        held      = bus.result;
        stable_ok = 1'b1;
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            if (!bus.out_valid || bus.in_ready || bus.result !== held || bus.err !== exp_err)
                stable_ok = 1'b0;
        end
        if (hold > 0) chk({name, ".held_stable"}, 32'(stable_ok), 32'd1);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk({name, ".drained"}, {29'd0, bus.out_valid, bus.in_ready, bus.busy}, 32'b010);
    endtask

    initial begin
        logic [1:0]    rop;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;
        logic [RW-1:0] rres;
        logic          rerr;
        int            rlat;
        int            rhold;

        n_pass        = 0;
        n_total       = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.op        = 2'd0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;

        vecs[0]  = '{2'd0, 8'd10,  8'd20,  0, 16'd30,    1'b0, 1};
        vecs[1]  = '{2'd1, 8'd10,  8'd20,  0, 16'd200,   1'b0, 1};
        vecs[2]  = '{2'd2, 8'd10,  8'd20,  0, 16'd230,   1'b0, 1};
        vecs[3]  = '{2'd2, 8'd255, 8'd255, 1, 16'd65535, 1'b0, 1};
        vecs[4]  = '{2'd0, 8'd255, 8'd255, 0, 16'd510,   1'b0, 1};
        vecs[5]  = '{2'd1, 8'd3,   8'd7,   5, 16'd21,    1'b0, 1};
`ifdef CALC_DIV_EN
        vecs[6]  = '{2'd3, 8'd40,  8'd50,  0, 16'd22,    1'b0, 17};
        vecs[7]  = '{2'd3, 8'd0,   8'd0,   0, 16'hFFFF,  1'b1, 1};
        vecs[8]  = '{2'd3, 8'd255, 8'd255, 2, 16'd127,   1'b0, 17};
        vecs[9]  = '{2'd3, 8'd1,   8'd0,   0, 16'd0,     1'b0, 17};
`else
        vecs[6]  = '{2'd3, 8'd40,  8'd50,  0, 16'd0,     1'b1, 1};
        vecs[7]  = '{2'd3, 8'd0,   8'd0,   0, 16'd0,     1'b1, 1};
        vecs[8]  = '{2'd3, 8'd255, 8'd255, 2, 16'd0,     1'b1, 1};
        vecs[9]  = '{2'd3, 8'd1,   8'd0,   0, 16'd0,     1'b1, 1};
`endif
        vecs[10] = '{2'd0, 8'd0,   8'd0,   0, 16'd0,     1'b0, 1};
        vecs[11] = '{2'd1, 8'd255, 8'd1,   3, 16'd255,   1'b0, 1};

        #12;
        chk("reset.outputs", {27'd0, bus.in_ready, bus.out_valid, bus.busy, bus.err, 1'b0}, 32'b10000);
        chk("reset.result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < NVEC; i++) begin
            run_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hold,
                    vecs[i].res, vecs[i].err, vecs[i].lat);
        end

        for (int i = 0; i < NRAND; i++) begin
            rop   = 2'($urandom_range(0, 3));
            ra    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rb    = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
            rhold = $urandom_range(0, 3);
            model(rop, ra, rb, rres, rerr, rlat);
            run_txn($sformatf("rnd%0d_op%0d_%0d_%0d", i, rop, ra, rb), rop, ra, rb, rhold,
                    rres, rerr, rlat);
        end

        // Reset asserted during the 8th division cycle of RATIO 40,50.
        bus.op        = 2'd3;
        bus.a         = 8'd40;
        bus.b         = 8'd50;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #2;
        chk("middiv.busy_before_reset", 32'(bus.busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("middiv.reset_outputs", {27'd0, bus.in_ready, bus.out_valid, bus.busy, bus.err, 1'b0}, 32'b10000);
        chk("middiv.reset_result", 32'(bus.result), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_txn("after_reset_add", 2'd0, 8'd1, 8'd2, 0, 16'd3, 1'b0, 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
